// File: rtl/pc_gen_if.sv
// Fetch/redirect bus between the IF/EX stages and the program-counter unit.
// The pc_gen side uses the slave modport; the pipeline side uses master.
interface pc_gen_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
);
  logic            fetch_ready;
  logic            branch_taken;
  logic [XLEN-1:0] branch_pc;
  logic [XLEN-1:0] branch_imm;
  logic            jump_valid;
  logic [XLEN-1:0] jump_target;
  logic            trap_valid;
  logic            call_i;
  logic            ret_i;
  logic [XLEN-1:0] pc_out;
  logic            pc_valid;
  logic            misalign_err;
  logic [CNT_W-1:0] redirect_count;
  logic            ras_empty;

  modport master (
    output fetch_ready, branch_taken, branch_pc, branch_imm, jump_valid,
           jump_target, trap_valid, call_i, ret_i,
    input  pc_out, pc_valid, misalign_err, redirect_count, ras_empty
  );

  modport slave (
    input  fetch_ready, branch_taken, branch_pc, branch_imm, jump_valid,
           jump_target, trap_valid, call_i, ret_i,
    output pc_out, pc_valid, misalign_err, redirect_count, ras_empty
  );
endinterface

// File: rtl/pc_gen.sv
// Program-counter unit: boot hold, prioritised redirects (trap > branch > jump),
// alignment clearing, saturating redirect count. Optional return stack: PC_RAS_EN.
module pc_gen #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned     INSTR_BYTES  = 4,
  parameter int unsigned     BOOT_CYCLES  = 2,
  parameter int unsigned     CNT_W        = 16,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input logic     clk,
  input logic     reset,
  pc_gen_if.slave bus
);

  localparam int unsigned     BOOT_W     = $clog2(BOOT_CYCLES + 1);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);
  localparam logic [XLEN-1:0] STEP       = XLEN'(INSTR_BYTES);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic {S_BOOT, S_RUN} state_t;

  state_t           state_q, state_n;
  logic [BOOT_W-1:0] boot_q, boot_n;
  logic [XLEN-1:0]  pc_q, pc_n;
  logic             valid_q, valid_n;
  logic             mis_q, mis_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [XLEN-1:0]  target;
  logic [XLEN-1:0]  jump_dest;
  logic             redirect;
  logic             jump_sel;

  // Next-state and next-PC selection
  always_comb begin
    state_n  = state_q;
    boot_n   = boot_q;
    pc_n     = pc_q;
    valid_n  = valid_q;
    mis_n    = 1'b0;
    cnt_n    = cnt_q;
    target   = pc_q;
    redirect = 1'b0;
    jump_sel = 1'b0;
    case (state_q)
      S_BOOT: begin
        valid_n = 1'b0;
        if (boot_q <= BOOT_W'(1)) begin
          state_n = S_RUN;
          valid_n = 1'b1;
        end else begin
          boot_n = boot_q - BOOT_W'(1);
        end
      end
      S_RUN: begin
        valid_n = 1'b1;
        if (bus.trap_valid) begin
          target   = TRAP_VECTOR;
          redirect = 1'b1;
        end else if (bus.branch_taken) begin
          target   = bus.branch_pc + bus.branch_imm;
          redirect = 1'b1;
        end else if (bus.jump_valid) begin
          target   = jump_dest;
          redirect = 1'b1;
          jump_sel = 1'b1;
        end else if (bus.fetch_ready) begin
          pc_n = pc_q + STEP;
        end
        if (redirect) begin
          pc_n  = target & ~ALIGN_MASK;
          mis_n = |(target & ALIGN_MASK);
          if (cnt_q != CNT_MAX) cnt_n = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_BOOT;
      boot_q  <= BOOT_W'(BOOT_CYCLES);
      pc_q    <= RESET_VECTOR;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      boot_q  <= boot_n;
      pc_q    <= pc_n;
      valid_q <= valid_n;
      mis_q   <= mis_n;
      cnt_q   <= cnt_n;
    end
  end

  assign bus.pc_out         = pc_q;
  assign bus.pc_valid       = valid_q;
  assign bus.misalign_err   = mis_q;
  assign bus.redirect_count = cnt_q;

`ifdef PC_RAS_EN
  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned DEP_W = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] top_q, top_n, push_ptr;
  logic [DEP_W-1:0] depth_q, depth_n;
  logic             empty_q;
  logic             push, pop;

  // Call wins over return; a higher-priority redirect clears jump_sel
  assign push      = jump_sel & bus.call_i;
  assign pop       = jump_sel & bus.ret_i & ~bus.call_i & (depth_q != '0);
  assign push_ptr  = (top_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : top_q + PTR_W'(1);
  assign jump_dest = (bus.ret_i && !bus.call_i && depth_q != '0) ? ras_mem[top_q]
                                                                 : bus.jump_target;

  always_comb begin
    top_n   = top_q;
    depth_n = depth_q;
    if (push) begin
      top_n = push_ptr;
      if (depth_q != DEP_W'(RAS_DEPTH)) depth_n = depth_q + DEP_W'(1);
    end else if (pop) begin
      top_n   = (top_q == '0) ? PTR_W'(RAS_DEPTH - 1) : top_q - PTR_W'(1);
      depth_n = depth_q - DEP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      top_q   <= '0;
      depth_q <= '0;
      empty_q <= 1'b1;
    end else begin
      top_q   <= top_n;
      depth_q <= depth_n;
      empty_q <= (depth_n == '0);
    end
  end

  // Full stack: the write wraps onto the oldest slot
  always_ff @(posedge clk) begin
    if (reset && push) ras_mem[push_ptr] <= pc_q + STEP;
  end

  assign bus.ras_empty = empty_q;
`else
  wire unused_ras = bus.call_i ^ bus.ret_i;
  assign jump_dest     = bus.jump_target;
  assign bus.ras_empty = 1'b1;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: randomized and directed stimulus, expectations
// from a behavioural model, checked by an independent monitor.
module tb_pc_gen;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned BOOT  = 2;
  localparam int unsigned IB    = 4;
  localparam int unsigned RDEP  = 4;
  localparam logic [31:0] RV    = 32'h0000_0000;
  localparam logic [31:0] TV    = 32'h0000_0100;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_gen_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  pc_gen #(
    .XLEN(XLEN), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .INSTR_BYTES(IB),
    .BOOT_CYCLES(BOOT), .CNT_W(CNT_W), .RAS_DEPTH(RDEP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        mis;
    logic [31:0] cnt;
    logic        empty;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic [31:0] m_pc;
  int          m_boot;
  int          m_cnt;
  bit          m_mis;
  logic [31:0] m_stk[$];

  task automatic step(input bit rst, input bit fr, input bit bt,
                      input logic [31:0] bpc, input logic [31:0] bimm,
                      input bit jv, input logic [31:0] jt,
                      input bit tv, input bit cl, input bit rt);
    exp_t        e;
    logic [31:0] tgt;
    bit          redir;
    reset            = rst;
    bus.fetch_ready  = fr;
    bus.branch_taken = bt;
    bus.branch_pc    = bpc;
    bus.branch_imm   = bimm;
    bus.jump_valid   = jv;
    bus.jump_target  = jt;
    bus.trap_valid   = tv;
    bus.call_i       = cl;
    bus.ret_i        = rt;
    if (!rst) begin
      m_pc = RV; m_boot = BOOT; m_cnt = 0; m_mis = 0;
      m_stk.delete();
    end else if (m_boot > 0) begin
      m_boot--;
      m_mis = 0;
    end else begin
      redir = 1;
      if (tv) tgt = TV;
      else if (bt) tgt = bpc + bimm;
      else if (jv) begin
        tgt = jt;
`ifdef PC_RAS_EN
        if (cl) begin
          m_stk.push_back(m_pc + IB);
          if (m_stk.size() > RDEP) void'(m_stk.pop_front());
        end else if (rt && m_stk.size() > 0) begin
          tgt = m_stk.pop_back();
        end
`endif
      end else begin
        redir = 0;
        tgt = fr ? m_pc + IB : m_pc;
      end
      m_mis = redir && (tgt % IB != 0);
      m_pc  = tgt - (tgt % IB);
      if (redir && m_cnt < (2 ** CNT_W) - 1) m_cnt++;
    end
    e.pc    = m_pc;
    e.valid = (m_boot == 0);
    e.mis   = m_mis;
    e.cnt   = 32'(m_cnt);
    e.empty = (m_stk.size() == 0);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit fr);
    step(1, fr, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic jump(input logic [31:0] jt, input bit cl, input bit rt);
    step(1, 0, 0, 0, 0, 1, jt, 0, cl, rt);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
    end
  endtask

  // Monitor: compares DUT outputs after each edge against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_out", bus.pc_out, e.pc);
        chk("pc_valid", 32'(bus.pc_valid), 32'(e.valid));
        chk("misalign_err", 32'(bus.misalign_err), 32'(e.mis));
        chk("redirect_count", 32'(bus.redirect_count), e.cnt);
        chk("ras_empty", 32'(bus.ras_empty), 32'(e.empty));
      end
    end
  end

  initial begin
    logic [31:0] r, jt, bpc, bimm;
    bit          cl, rt;
    m_pc = RV; m_boot = BOOT; m_cnt = 0; m_mis = 0;
    step(0, 1, 1, 32'h20, 32'h40, 1, 32'h80, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    // Boot hold then sequential fetch
    repeat (5) idle(1);
    jump(32'h10, 0, 0);
    repeat (3) idle(0);
    repeat (2) idle(1);
    // All three redirects together, then branch + jump
    step(1, 1, 1, 32'h20, 32'hFFFF_FFF0, 1, 32'h300, 1, 0, 0);
    step(1, 1, 1, 32'h20, 32'hFFFF_FFF0, 1, 32'h300, 0, 0, 0);
    jump(32'h0000_0046, 0, 0);
    repeat (2) idle(1);
    jump(32'hFFFF_FFFC, 0, 0);
    repeat (2) idle(1);
    // Reset mid-run while a branch is requested
    step(0, 1, 1, 32'h20, 32'h40, 0, 0, 0, 0, 0);
    repeat (4) idle(1);
`ifdef PC_RAS_EN
    jump(32'h40, 0, 0);
    jump(32'h200, 1, 0);
    jump(32'h999, 0, 1);
    for (int i = 0; i < 5; i++) begin
      jump(32'h1000 + 32'(i) * 32'h10, 1, 0);
      idle(1);
    end
    for (int i = 0; i < 5; i++) jump(32'h999, 0, 1);
    idle(1);
`endif
    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      r    = $urandom;
      jt   = $urandom;
      bpc  = $urandom & 32'hFFFF_FFFC;
      bimm = 32'($urandom_range(0, 511)) - 32'd256;
      if (r[5:4] != 2'b00) jt[1:0] = 2'b00;
      cl = (r[13:12] == 2'b01);
      rt = (r[13:12] == 2'b10);
      step(r[31:24] != 8'h00, r[1:0] != 2'b00, r[8:6] == 3'b000, bpc, bimm,
           r[11:9] < 3'd2, jt, r[17:14] == 4'h0, cl, rt);
    end
    #5;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised next-generation program-counter unit for the pipelined core. Holds the fetch PC in a register and advances it sequentially under an IF-stage handshake.
- Applies redirects in fixed priority: trap, then branch (PC-relative), then jump (absolute).
- Adds a boot hold state, misalignment detection and a saturating redirect counter.
- Sits between the IF stage / instruction memory and the EX-stage branch resolution logic.

Parameters:
- XLEN, 32, width of PC, immediate and target datapaths.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC value loaded on trap.
- INSTR_BYTES, 4, sequential increment; power of two.
- BOOT_CYCLES, 2, cycles pc_valid stays low after reset release; must be at least 1.
- CNT_W, 16, width of redirect_count.
- RAS_DEPTH, 4, return-address stack entries; used only with PC_RAS_EN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset asserted).
- fetch_ready  in  1  IF accepts pc_out this cycle.
- branch_taken  in  1  EX resolved a taken branch.
- branch_pc  in  XLEN  PC of the branch instruction.
- branch_imm  in  XLEN  sign-extended byte offset.
- jump_valid  in  1  absolute jump request.
- jump_target  in  XLEN  absolute jump address.
- trap_valid  in  1  exception/interrupt redirect.
- call_i  in  1  jump is a call; push return address (PC_RAS_EN only).
- ret_i  in  1  jump is a return; use the stack top (PC_RAS_EN only).
- pc_out  out  XLEN  current fetch PC.
- pc_valid  out  1  pc_out valid for fetch.
- misalign_err  out  1  one-cycle pulse: last redirect target was misaligned.
- redirect_count  out  CNT_W  saturating count of applied redirects.
- ras_empty  out  1  return stack empty.

Behaviour:
- Reset (reset==0 at a clock edge):
  - pc_out=RESET_VECTOR, pc_valid=0, misalign_err=0, redirect_count=0, ras_empty=1, state=BOOT.
  - The boot counter loads BOOT_CYCLES.
  - Reset takes priority over all other inputs in every state, including mid-operation.
- State BOOT:
  - pc_valid=0 and pc_out holds RESET_VECTOR.
  - The counter decrements each cycle; at 1 the state moves to RUN.
  - Redirects during BOOT are ignored and not counted.
  - First pc_valid=1 occurs BOOT_CYCLES cycles after reset is released.
- State RUN: pc_valid=1. The next PC is chosen by first match:
  1. trap_valid -> TRAP_VECTOR
  2. branch_taken -> branch_pc + branch_imm
  3. jump_valid -> jump_target (or stack top; see Optional Feature)
  4. fetch_ready -> pc_out + INSTR_BYTES
  5. otherwise hold pc_out.
- Redirect timing and counting:
  - Redirects are applied regardless of fetch_ready, with 1-cycle latency: request at edge N, target on pc_out after edge N.
  - Simultaneous redirects: only the highest-priority one is applied, and redirect_count increments by exactly 1.
- Arithmetic:
  - All additions are modulo 2^XLEN; wrap-around is silent.
  - Example: 32'hFFFF_FFFC + 4 = 0.
- Alignment:
  - If any of the low log2(INSTR_BYTES) bits of the selected target are nonzero, pc_out receives the target with those bits cleared.
  - misalign_err pulses high for exactly the cycle in which the cleared value appears on pc_out.
  - Sequential increments never raise misalign_err.
- redirect_count saturates at 2^CNT_W-1 and does not wrap.
- All outputs are registered; there are no combinational input-to-output paths.

Optional Feature:
- Macro: PC_RAS_EN.
- Defined:
  - A circular return-address stack of RAS_DEPTH entries with a depth counter.
  - jump_valid && call_i (when jump is the selected redirect): push pc_out + INSTR_BYTES, and redirect to jump_target.
  - jump_valid && ret_i with stack non-empty: pop, and redirect to the popped address instead of jump_target.
  - ret_i with stack empty: use jump_target.
  - Push when full overwrites the oldest entry; the depth stays at RAS_DEPTH.
  - A trap or branch in the same cycle suppresses push and pop.
  - ras_empty reflects depth==0 and is registered.
  - Reset empties the stack.
- Undefined:
  - No stack storage; call_i and ret_i are ignored.
  - ras_empty is tied to 1.
  - All other behaviour is identical.

Test Plan:
- Release reset with BOOT_CYCLES=2, fetch_ready=1 -> pc_valid=0 for 2 cycles, then pc_out 0x0, 0x4, 0x8 on consecutive cycles.
- In RUN at pc_out=0x10, drop fetch_ready for 3 cycles -> pc_out holds 0x10, then resumes 0x14.
- Same cycle: trap_valid=1, branch_taken=1 (branch_pc=0x20, imm=0xFFFF_FFF0), jump_valid=1 -> next pc_out=0x100; redirect_count +1. Repeat without trap -> pc_out=0x10.
- jump_target=0x0000_0046 -> pc_out=0x44 and misalign_err=1 for one cycle. Separately, pc_out=0xFFFF_FFFC with fetch_ready=1 -> wraps to 0x0 with no error.
- Assert reset for 1 cycle while branch_taken=1 -> pc_out=RESET_VECTOR, redirect_count=0, BOOT re-entered.
- PC_RAS_EN, RAS_DEPTH=4:
  - Call from 0x40 to 0x200, then ret with jump_target=0x999 -> pc_out=0x44.
  - 5 calls, then 5 rets -> first 4 pops return the newest addresses, 5th uses jump_target.
  - ras_empty=1 at the end.
